// File: rtl/serial_add_pkg.sv
// Shared constants for the bit-serial adder controller: FSM encoding and default width.
package serial_add_pkg;

    localparam int DEFAULT_N = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder; the only arithmetic resource shared by the serial controller.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    assign s     = x ^ y ^ c_in;
    assign c_out = (x & y) | (c_in & (x ^ y));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_adder stepped over N-bit operands LSB first, start/done handshake.
// Define SERIAL_ADD_OVF_EN to add the two's-complement overflow output ovf.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         c_out
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state_q, state_d;
    logic [N-1:0]  a_sr_q, a_sr_d;
    logic [N-1:0]  b_sr_q, b_sr_d;
    logic [N-1:0]  sum_sr_q, sum_sr_d;
    logic          carry_q, carry_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  sum_q, sum_d;
    logic          c_out_q, c_out_d;
`ifdef SERIAL_ADD_OVF_EN
    logic          c_msb_q, c_msb_d;
    logic          ovf_q, ovf_d;
`endif

    logic fa_s, fa_c;

    full_adder u_fa (
        .x     (a_sr_q[0]),
        .y     (b_sr_q[0]),
        .c_in  (carry_q),
        .s     (fa_s),
        .c_out (fa_c)
    );

    always_comb begin
        // NOTE: every next-state value starts as a copy of its register, so no branch leaves one unassigned and no latch is inferred.
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        c_out_d  = c_out_q;
`ifdef SERIAL_ADD_OVF_EN
        c_msb_d  = c_msb_q;
        ovf_d    = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = c_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                // Each result bit enters at the MSB; after N shifts bit 0 sits at position 0.
                sum_sr_d = {fa_s, sum_sr_q[N-1:1]};
                carry_d  = fa_c;
                if (cnt_q == LAST) begin
                    state_d = FINISH;
`ifdef SERIAL_ADD_OVF_EN
                    c_msb_d = carry_q;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            FINISH: begin
                sum_d   = sum_sr_q;
                c_out_d = carry_q;
`ifdef SERIAL_ADD_OVF_EN
                ovf_d   = c_msb_q ^ carry_q;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, matching the hardware.
        if (reset) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            c_out_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            c_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            c_out_q  <= c_out_d;
`ifdef SERIAL_ADD_OVF_EN
            c_msb_q  <= c_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy  = (state_q == RUN);
    assign done  = (state_q == FINISH);
    // During the done cycle the completed shift register is shown directly, so the result is valid with done.
    assign sum   = done ? sum_sr_q : sum_q;
    assign c_out = done ? carry_q  : c_out_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf   = done ? (c_msb_q ^ carry_q) : ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: latency/arithmetic model checked every cycle plus directed literals.
module tb_serial_add_ctrl;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] a, b;
    logic         c_in;
    logic         busy, done;
    logic [N-1:0] sum;
    logic         c_out;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1..N busy, N+1 done; result computed by plain arithmetic at accept.
    int           phase   = 0;
    logic [N:0]   pend    = '0;
    logic [N:0]   exp_res = '0;
    bit           pend_ovf = 1'b0;
    bit           exp_ovf  = 1'b0;

    function automatic bit signed_ovf(input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
        int sx, sy, s;
        sx = x[N-1] ? int'(x) - (1 << N) : int'(x);
        sy = y[N-1] ? int'(y) - (1 << N) : int'(y);
        s  = sx + sy + int'(c);
        return (s > (1 << (N - 1)) - 1) || (s < -(1 << (N - 1)));
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            phase   <= 0;
            exp_res <= '0;
            exp_ovf <= 1'b0;
        end else if (phase == 0) begin
            if (start) begin
                pend     <= (N + 1)'(a) + (N + 1)'(b) + (N + 1)'(c_in);
                pend_ovf <= signed_ovf(a, b, c_in);
                phase    <= 1;
            end
        end else if (phase == N) begin
            phase   <= N + 1;
            exp_res <= pend;
            exp_ovf <= pend_ovf;
        end else if (phase == N + 1) begin
            phase <= 0;
        end else begin
            phase <= phase + 1;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("busy",  busy,  (phase >= 1 && phase <= N));
            check("done",  done,  (phase == N + 1));
            check("sum",   sum,   exp_res[N-1:0]);
            check("c_out", c_out, exp_res[N]);
`ifdef SERIAL_ADD_OVF_EN
            check("ovf",   ovf,   exp_ovf);
`endif
        end
    end

    task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input logic tc,
                          input logic [N:0] exp, input bit exp_v, input string tag);
        int lat;
        @(negedge clk);
        a = ta; b = tb_v; c_in = tc; start = 1'b1;
        lat = 0;
        for (int i = 1; i <= 3 * N; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat = i;
                break;
            end
        end
        check({tag, " latency"}, lat, N + 1);
        check({tag, " sum"}, sum, exp[N-1:0]);
        check({tag, " c_out"}, c_out, exp[N]);
`ifdef SERIAL_ADD_OVF_EN
        check({tag, " ovf"}, ovf, exp_v);
`else
        if (exp_v && 1'b0) check({tag, " ovf"}, 0, 1);
`endif
    endtask

    int dcount;

    initial begin
        reset = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
        @(negedge clk);
        checking = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset sum", sum, 0);
        check("reset c_out", c_out, 0);
        dcount = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("idle no done", dcount, 0);

        run_op(8'h05, 8'h03, 1'b0, 9'h008, 1'b0, "basic");
        run_op(8'hFF, 8'h00, 1'b1, 9'h100, 1'b0, "chain1");
        run_op(8'hFF, 8'hFF, 1'b1, 9'h1FF, 1'b0, "chain2");
        run_op(8'h7F, 8'h01, 1'b0, 9'h080, 1'b1, "ovf_pos");
        run_op(8'h80, 8'h80, 1'b0, 9'h100, 1'b1, "ovf_neg");
        run_op(8'h10, 8'h20, 1'b0, 9'h030, 1'b0, "no_ovf");

        // Start and operand changes while busy must be ignored.
        @(negedge clk);
        a = 8'h11; b = 8'h22; c_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; a = 8'hFF; b = 8'hFF; c_in = 1'b1;
        @(negedge clk);
        a = 8'hAA; b = 8'h55;
        @(negedge clk);
        start = 1'b0;
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("busy start done count", dcount, 1);
        check("busy start sum", sum, 8'h33);

        // Reset in the fourth RUN cycle.
        @(negedge clk);
        a = 8'h40; b = 8'h41; c_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset busy", busy, 0);
        check("midreset sum", sum, 0);
        check("midreset c_out", c_out, 0);
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("midreset no done", dcount, 0);
        run_op(8'h12, 8'h34, 1'b1, 9'h047, 1'b0, "after_reset");

        // Randomized traffic, including held start and rare resets.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) != 0);
            a     = N'($urandom);
            b     = N'($urandom);
            c_in  = 1'($urandom);
            reset = ($urandom_range(0, 99) == 0);
        end
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        repeat (2 * N + 2) @(negedge clk);
        checking = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
